// File: rtl/alu_pkg.sv
// Shared opcode encoding and saturation bounds for the SIMD integer ALU pipe.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } alu_op_t;

  function automatic longint max_pos(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  function automatic longint max_neg(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/alu_integer_pipe_if.sv
// Operand/result bundle of the SIMD ALU pipe; valid/ready on both the input and output side.
interface alu_integer_pipe_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
);

  logic                        in_valid;
  logic                        in_ready;
  alu_op_t                     opcode;
  logic [LANES*DATA_WIDTH-1:0] A;
  logic [LANES*DATA_WIDTH-1:0] B;
  logic                        acc_clr;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] Out;
  logic [LANES-1:0]            V;
  logic [LANES-1:0]            N;
  logic [LANES-1:0]            Z;
  logic [LANES-1:0]            V_sticky;
  logic                        clr_sticky;

  modport master (
    output in_valid, opcode, A, B, acc_clr, out_ready, clr_sticky,
    input  in_ready, out_valid, Out, V, N, Z, V_sticky
  );

  modport slave (
    input  in_valid, opcode, A, B, acc_clr, out_ready, clr_sticky,
    output in_ready, out_valid, Out, V, N, Z, V_sticky
  );

endinterface

// File: rtl/alu_lane_sat.sv
// One ALU lane, purely combinational: full-precision op on the input side and an
// independent saturator fed from the stage-1 register.
module alu_lane_sat
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  alu_op_t                       op_i,
  input  logic signed [DATA_WIDTH-1:0]  a_i,
  input  logic signed [DATA_WIDTH-1:0]  b_i,
  input  logic signed [DATA_WIDTH-1:0]  acc_i,
  output logic signed [2*DATA_WIDTH:0]  full_o,
  input  logic signed [2*DATA_WIDTH:0]  full_i,
  output logic signed [DATA_WIDTH-1:0]  sat_o,
  output logic                          v_o
);

  localparam int FW = 2 * DATA_WIDTH + 1;
  localparam logic signed [FW-1:0] MAX_P = FW'(max_pos(DATA_WIDTH));
  localparam logic signed [FW-1:0] MAX_N = FW'(max_neg(DATA_WIDTH));

  logic signed [FW-1:0] a_x;
  logic signed [FW-1:0] b_x;
  logic signed [FW-1:0] acc_x;
  logic signed [FW-1:0] prod;

  assign a_x   = {{(FW-DATA_WIDTH){a_i[DATA_WIDTH-1]}}, a_i};
  assign b_x   = {{(FW-DATA_WIDTH){b_i[DATA_WIDTH-1]}}, b_i};
  assign acc_x = {{(FW-DATA_WIDTH){acc_i[DATA_WIDTH-1]}}, acc_i};
  assign prod  = a_x * b_x;

  always_comb begin
    full_o = a_x + b_x;
    case (op_i)
      OP_ADD:  full_o = a_x + b_x;
      OP_SUB:  full_o = a_x - b_x;
      OP_MUL:  full_o = prod;
      OP_MAC:  full_o = acc_x + prod;
      default: full_o = a_x + b_x;
    endcase
  end

  // Bounds themselves are representable, so only strict excess clamps.
  always_comb begin
    sat_o = full_i[DATA_WIDTH-1:0];
    v_o   = 1'b0;
    if (full_i > MAX_P) begin
      sat_o = MAX_P[DATA_WIDTH-1:0];
      v_o   = 1'b1;
    end else if (full_i < MAX_N) begin
      sat_o = MAX_N[DATA_WIDTH-1:0];
      v_o   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_integer_pipe.sv
// Two-stage SIMD integer ALU: S1 holds full-precision results, S2 the saturated Out and flags.
// Latency 2 cycles; the whole pipe stalls only when S2 is full and out_ready is low.
module alu_integer_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_integer_pipe_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int FW = 2 * DW + 1;

  logic                         s1_vld_q, s1_vld_d;
  alu_op_t                      s1_op_q, s1_op_d;
  logic [LANES-1:0][FW-1:0]     s1_full_q, s1_full_d;
  logic [LANES-1:0][FW-1:0]     full;

  logic [LANES-1:0][DW-1:0]     acc_q, acc_d;
  logic [LANES-1:0][DW-1:0]     acc_fwd;
  logic [LANES-1:0][DW-1:0]     sat;
  logic [LANES-1:0]             sat_v;

  logic                         out_vld_q, out_vld_d;
  logic [LANES-1:0][DW-1:0]     out_q, out_d;
  logic [LANES-1:0]             v_q, v_d;
  logic [LANES-1:0]             n_q, n_d;
  logic [LANES-1:0]             z_q, z_d;
  logic [LANES-1:0]             stk_q, stk_d;

  logic                         s2_adv;
  logic                         s1_mv;
  logic                         in_rdy;
  logic                         accept;
  logic                         s1_mac;

  assign s2_adv = !out_vld_q || bus.out_ready;
  assign s1_mv  = s1_vld_q && s2_adv;
  assign in_rdy = !s1_vld_q || s2_adv;
  assign accept = bus.in_valid && in_rdy;
  assign s1_mac = s1_vld_q && (s1_op_q == OP_MAC);

  // A MAC in S1 commits its saturated value in the same edge that a new bundle is
  // accepted, so the incoming MAC must see that value rather than the stale register.
  assign acc_fwd = bus.acc_clr ? '0 : (s1_mac ? sat : acc_q);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    alu_lane_sat #(
      .DATA_WIDTH (DW)
    ) u_lane (
      .op_i   (bus.opcode),
      .a_i    (bus.A[g*DW +: DW]),
      .b_i    (bus.B[g*DW +: DW]),
      .acc_i  (acc_fwd[g]),
      .full_o (full[g]),
      .full_i (s1_full_q[g]),
      .sat_o  (sat[g]),
      .v_o    (sat_v[g])
    );
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_op_d   = s1_op_q;
    s1_full_d = s1_full_q;
    if (s1_mv) begin
      s1_vld_d = 1'b0;
    end
    if (accept) begin
      s1_vld_d  = 1'b1;
      s1_op_d   = bus.opcode;
      s1_full_d = full;
    end

    out_vld_d = s1_mv || (out_vld_q && !bus.out_ready);
    out_d     = out_q;
    v_d       = v_q;
    n_d       = n_q;
    z_d       = z_q;
    if (s1_mv) begin
      out_d = sat;
      v_d   = sat_v;
      for (int i = 0; i < LANES; i++) begin
        n_d[i] = sat[i][DW-1];
        z_d[i] = (sat[i] == '0);
      end
    end

    acc_d = acc_q;
    if (bus.acc_clr) begin
      acc_d = '0;
    end else if (s1_mv && s1_mac) begin
      acc_d = sat;
    end

    // A set arriving with the clear survives it.
    stk_d = (stk_q & ~{LANES{bus.clr_sticky}}) | (s1_mv ? sat_v : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_op_q   <= OP_ADD;
      s1_full_q <= '0;
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      v_q       <= '0;
      n_q       <= '0;
      z_q       <= '1;
      stk_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_op_q   <= s1_op_d;
      s1_full_q <= s1_full_d;
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      v_q       <= v_d;
      n_q       <= n_d;
      z_q       <= z_d;
      stk_q     <= stk_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld_q;
  assign bus.Out       = out_q;
  assign bus.V         = v_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.V_sticky  = stk_q;

endmodule
